// File: rtl/eda_scan_ctrl.sv
// Frame scan controller: streams an M x N image into RAM, then walks every center pixel through the regional-max evaluator.
// Optional WAIT watchdog is enabled by defining EDA_SCAN_TIMEOUT_EN.
module eda_scan_ctrl #(
    parameter int M           = 6,
    parameter int N           = 6,
    parameter int PIXEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = $clog2(M*N),
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PIXEL_WIDTH-1:0] s_pixel,
    output logic                   write_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [PIXEL_WIDTH-1:0] pixel_in,
    output logic [ADDR_WIDTH-1:0]  center_addr,
    output logic                   new_pixel,
    output logic                   clear,
    input  logic                   pix_done,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(M*N-1);

    if (TIMEOUT < 1 || M*N < 2 || (64'd1 << ADDR_WIDTH) < 64'(M*N)) begin : g_bad_cfg
        $error("eda_scan_ctrl: invalid parameter set");
    end

    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, ISSUE, WAIT, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic                  wait_expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_cnt      <= '0;
            s_ready     <= 1'b0;
            write_en    <= 1'b0;
            wr_addr     <= '0;
            pixel_in    <= '0;
            center_addr <= '0;
            new_pixel   <= 1'b0;
            clear       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        wr_cnt  <= '0;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        write_en <= 1'b1;
                        wr_addr  <= wr_cnt;
                        pixel_in <= s_pixel;
                        // The counter parks on the last address instead of wrapping.
                        if (wr_cnt == LAST) begin
                            state       <= CLEAR;
                            s_ready     <= 1'b0;
                            clear       <= 1'b1;
                            center_addr <= '0;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    state     <= ISSUE;
                    clear     <= 1'b0;
                    new_pixel <= 1'b1;
                end
                ISSUE: begin
                    state     <= WAIT;
                    new_pixel <= 1'b0;
                end
                WAIT: begin
                    if (pix_done || wait_expired) begin
                        if (center_addr == LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            center_addr <= center_addr + 1'b1;
                            new_pixel   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EDA_SCAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT+1);

    logic [TW-1:0] wait_cnt;

    // Expiry fires on the TIMEOUT-th consecutive WAIT cycle and advances the scan like pix_done.
    assign wait_expired = (state == WAIT) && !pix_done && (wait_cnt == TW'(TIMEOUT-1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != WAIT || pix_done || wait_expired) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (wait_expired) begin
                timeout_err <= 1'b1;
            end else if (state == IDLE && start) begin
                timeout_err <= 1'b0;
            end
        end
    end
`else
    assign wait_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_eda_scan_ctrl.sv
// Randomized bench for eda_scan_ctrl against a transaction-level model of load, scan, reset and watchdog behaviour.
module tb_eda_scan_ctrl;
    localparam int M  = 6;
    localparam int N  = 6;
    localparam int MN = M*N;
    localparam int PW = 8;
    localparam int AW = $clog2(MN);
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [PW-1:0] s_pixel = '0;
    logic          write_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] pixel_in;
    logic [AW-1:0] center_addr;
    logic          new_pixel;
    logic          clear;
    logic          pix_done = 1'b0;
    logic          busy;
    logic          done;
    logic          timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    logic exp_terr = 1'b0;

    eda_scan_ctrl #(.M(M), .N(N), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
        .write_en(write_en), .wr_addr(wr_addr), .pixel_in(pixel_in),
        .center_addr(center_addr), .new_pixel(new_pixel), .clear(clear),
        .pix_done(pix_done), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "global time limit");
    end

    task automatic test_reset;
        reset = 1'b1;
        #2;
        n_cmp++;
        if ({s_ready, write_en, wr_addr, pixel_in, center_addr, new_pixel, clear, busy, done, timeout_err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b s_ready=%b center=%0d, want all zero", busy, s_ready, center_addr);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_idle_ignore(input logic [AW-1:0] exp_center);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || s_ready !== 1'b0 || new_pixel !== 1'b0 || center_addr !== exp_center) begin
                n_err++;
                $display("FAIL idle_ignore: busy=%b s_ready=%b new_pixel=%b center=%0d, want 0/0/0/%0d",
                         busy, s_ready, new_pixel, center_addr, exp_center);
            end
            pix_done = 1'($urandom_range(0, 1));
        end
        pix_done = 1'b0;
    endtask

    task automatic do_start;
        @(negedge clk);
        s_valid = 1'b0;
        pix_done = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        exp_terr = 1'b0;
    endtask

    // Drives the frame and expects every accepted beat to appear on the write port one cycle later.
    task automatic run_load(input int gap_after, input bit rand_valid, input bit pix_is_addr);
        int            beats = 0;
        int            gap_cnt = 0;
        int            cyc = 0;
        bit            prev_beat = 1'b0;
        logic [PW-1:0] prev_pix = '0;
        logic [AW-1:0] exp_addr;
        bit            v;
        forever begin
            @(negedge clk);
            exp_addr = AW'(beats - 1);
            n_cmp++;
            if (s_ready !== (beats < MN) || write_en !== prev_beat || busy !== 1'b1 || done !== 1'b0
                || new_pixel !== 1'b0 || clear !== (beats == MN) || timeout_err !== exp_terr) begin
                n_err++;
                $display("FAIL load_ctrl: s_ready=%b write_en=%b clear=%b busy=%b terr=%b, want %b/%b/%b/1/%b (beats=%0d)",
                         s_ready, write_en, clear, busy, timeout_err, beats < MN, prev_beat, beats == MN, exp_terr, beats);
            end
            if (prev_beat) begin
                n_cmp++;
                if (wr_addr !== exp_addr || pixel_in !== prev_pix) begin
                    n_err++;
                    $display("FAIL load_write: wr_addr=%0d pixel_in=%0h, want %0d/%0h", wr_addr, pixel_in, exp_addr, prev_pix);
                end
            end
            if (beats == MN) begin
                n_cmp++;
                if (center_addr !== '0) begin
                    n_err++;
                    $display("FAIL clear_center: center_addr=%0d, want 0", center_addr);
                end
                s_valid = 1'b0;
                start = 1'b0;
                pix_done = 1'b0;
                return;
            end
            if (gap_after >= 0 && beats == gap_after + 1 && gap_cnt < 3) begin
                v = 1'b0;
                gap_cnt++;
            end else if (rand_valid) begin
                v = ($urandom_range(0, 3) != 0);
            end else begin
                v = 1'b1;
            end
            s_valid = v;
            s_pixel = pix_is_addr ? PW'(beats) : PW'($urandom);
            start = 1'($urandom_range(0, 1));
            pix_done = 1'($urandom_range(0, 1));
            prev_beat = v;
            if (v) begin
                prev_pix = s_pixel;
                beats++;
            end
            cyc++;
            if (cyc > 2000) begin
                n_err++;
                $display("FAIL load_budget: only %0d of %0d beats accepted", beats, MN);
                s_valid = 1'b0;
                return;
            end
        end
    endtask

    // Walks all centers; stall_at withholds pix_done, abort_at resets inside WAIT at that center.
    task automatic run_scan(input bit rand_mode, input int stall_at, input int abort_at);
        int            nwait;
        bit            release_done;
        logic [AW-1:0] exp_c;
        for (int c = 0; c < MN; c++) begin
            exp_c = AW'(c);
            @(negedge clk);
            n_cmp++;
            if (new_pixel !== 1'b1 || center_addr !== exp_c || clear !== 1'b0 || busy !== 1'b1
                || done !== 1'b0 || s_ready !== 1'b0 || write_en !== 1'b0 || timeout_err !== exp_terr) begin
                n_err++;
                $display("FAIL issue: new_pixel=%b center=%0d clear=%b busy=%b done=%b terr=%b, want 1/%0d/0/1/0/%b",
                         new_pixel, center_addr, clear, busy, done, timeout_err, c, exp_terr);
            end
            pix_done = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            start = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c == stall_at) begin
`ifdef EDA_SCAN_TIMEOUT_EN
                nwait = TO;
                release_done = 1'b0;
`else
                nwait = TO + 8;
                release_done = 1'b1;
`endif
            end else begin
                nwait = rand_mode ? $urandom_range(1, 5) : 2;
                release_done = 1'b1;
            end
            for (int k = 0; k < nwait; k++) begin
                @(negedge clk);
                n_cmp++;
                if (new_pixel !== 1'b0 || center_addr !== exp_c || done !== 1'b0 || busy !== 1'b1 || timeout_err !== exp_terr) begin
                    n_err++;
                    $display("FAIL wait: new_pixel=%b center=%0d done=%b busy=%b terr=%b, want 0/%0d/0/1/%b (k=%0d)",
                             new_pixel, center_addr, done, busy, timeout_err, c, exp_terr, k);
                end
                if (c == abort_at) begin
                    #2 reset = 1'b1;
                    #1;
                    n_cmp++;
                    if ({s_ready, write_en, wr_addr, pixel_in, center_addr, new_pixel, clear, busy, done, timeout_err} !== '0) begin
                        n_err++;
                        $display("FAIL async_reset: busy=%b center=%0d new_pixel=%b, want all zero", busy, center_addr, new_pixel);
                    end
                    pix_done = 1'b0;
                    start = 1'b0;
                    repeat (2) begin
                        @(negedge clk);
                        n_cmp++;
                        if (done !== 1'b0 || busy !== 1'b0) begin
                            n_err++;
                            $display("FAIL reset_hold: done=%b busy=%b, want 0/0", done, busy);
                        end
                    end
                    reset = 1'b0;
                    exp_terr = 1'b0;
                    return;
                end
                pix_done = release_done && (k == nwait - 1);
                start = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (!release_done) exp_terr = 1'b1;
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || new_pixel !== 1'b0 || busy !== 1'b1 || center_addr !== AW'(MN - 1) || timeout_err !== exp_terr) begin
            n_err++;
            $display("FAIL done_pulse: done=%b new_pixel=%b busy=%b center=%0d terr=%b, want 1/0/1/%0d/%b",
                     done, new_pixel, busy, center_addr, timeout_err, MN - 1, exp_terr);
        end
        pix_done = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
                n_err++;
                $display("FAIL after_done: done=%b busy=%b s_ready=%b, want 0/0/0 (cycle %0d)", done, busy, s_ready, i);
            end
        end
    endtask

    task automatic test_frame_basic;
        do_start();
        run_load(-1, 1'b0, 1'b1);
        run_scan(1'b0, -1, -1);
        test_idle_ignore(AW'(MN - 1));
    endtask

    task automatic test_load_gap;
        do_start();
        run_load(10, 1'b0, 1'b0);
        run_scan(1'b1, -1, -1);
    endtask

    task automatic test_reset_midframe;
        do_start();
        run_load(-1, 1'b1, 1'b0);
        run_scan(1'b0, -1, 17);
        test_idle_ignore('0);
    endtask

    task automatic test_back_to_back;
        for (int f = 0; f < 3; f++) begin
            do_start();
            run_load(-1, 1'b1, 1'b0);
            run_scan(1'b1, -1, -1);
        end
    endtask

    task automatic test_timeout;
        do_start();
        run_load(-1, 1'b0, 1'b0);
        run_scan(1'b0, 5, -1);
        do_start();
        run_load(-1, 1'b1, 1'b0);
        run_scan(1'b0, -1, -1);
    endtask

    initial begin
        test_reset();
        test_idle_ignore('0);
        test_frame_basic();
        test_load_gap();
        test_reset_midframe();
        test_back_to_back();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/eda_scan_ctrl.md
EDA_SCAN_CTRL -- requirements
Module: eda_scan_ctrl

Interface
REQ-001 SHALL have parameter M, default 6, meaning image rows.
REQ-002 SHALL have parameter N, default 6, meaning image columns.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 8, meaning pixel bits.
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(M*N), meaning linear pixel address width.
REQ-005 SHALL have parameter TIMEOUT, default 64, meaning the per-pixel watchdog limit in cycles.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1, meaning a frame request pulse.
REQ-009 SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_pixel (input, PIXEL_WIDTH), meaning the raster-order pixel stream.
REQ-010 SHALL have ports write_en (output, 1), wr_addr (output, ADDR_WIDTH) and pixel_in (output, PIXEL_WIDTH), meaning the image RAM write port.
REQ-011 SHALL have ports center_addr (output, ADDR_WIDTH), new_pixel (output, 1) and clear (output, 1), meaning the regional-max evaluation controls.
REQ-012 SHALL have port pix_done, input, 1, meaning the evaluation of the current center has finished.
REQ-013 SHALL have ports busy (output, 1), done (output, 1) and timeout_err (output, 1), meaning status.

Function
REQ-014 SHALL implement the states IDLE, LOAD, CLEAR, ISSUE, WAIT and DONE.
REQ-015 IDLE: start=1 SHALL go to LOAD with the write counter at 0; start SHALL be ignored in every other state.
REQ-016 LOAD: s_ready SHALL be 1; a beat (s_valid&s_ready) in cycle k SHALL produce write_en=1, wr_addr=count and pixel_in=s_pixel, registered, in cycle k+1.
REQ-017 LOAD: the counter SHALL increment per beat; the beat at count M*N-1 SHALL move to CLEAR; s_valid=0 SHALL stall without writes.
REQ-018 s_ready SHALL be 0 in every state except LOAD; write_en SHALL be 1 only on the cycle after an accepted beat.
REQ-019 CLEAR: clear SHALL be 1 for exactly one cycle, center_addr SHALL be 0, and the FSM SHALL go to ISSUE.
REQ-020 ISSUE: new_pixel SHALL be 1 for exactly one cycle, followed by WAIT; center_addr SHALL stay stable from ISSUE through WAIT.
REQ-021 WAIT: pix_done=1 with center_addr<M*N-1 SHALL increment center_addr and go to ISSUE; with center_addr=M*N-1 it SHALL go to DONE.
REQ-022 pix_done SHALL be ignored outside WAIT, including on the ISSUE cycle.
REQ-023 DONE: done SHALL be 1 for one cycle, followed by IDLE; a start on that cycle SHALL be ignored.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Counters SHALL never wrap past M*N-1; arithmetic SHALL be unsigned at ADDR_WIDTH.
REQ-026 Minimum frame length SHALL be M*N beats + 1 CLEAR cycle + M*N×(ISSUE+WAIT) + 1 DONE cycle.

Reset
REQ-027 reset=1 SHALL immediately force IDLE and clear all counters, independent of clk.
REQ-028 During reset, s_ready, write_en, wr_addr, pixel_in, center_addr, new_pixel, clear, busy, done and timeout_err SHALL all be 0.
REQ-029 Reset in any state mid-frame SHALL abandon the frame with no done pulse; the next start SHALL begin a fresh LOAD at address 0.

Configuration
REQ-030 The macro EDA_SCAN_TIMEOUT_EN, when defined, SHALL add a WAIT cycle counter; TIMEOUT consecutive WAIT cycles without pix_done SHALL set timeout_err (sticky until reset or the next start) and advance exactly as if pix_done had arrived.
REQ-031 Without EDA_SCAN_TIMEOUT_EN, timeout_err SHALL be tied to 0 and WAIT SHALL last until pix_done, indefinitely if necessary.

Verification
REQ-032 Setup M=N=6, start, 36 back-to-back beats with pixel=addr -> 36 writes with wr_addr 0..35 each one cycle after acceptance, then clear=1 for one cycle.
REQ-033 s_valid deasserted for 3 cycles after beat 10 -> no write_en during the gap, wr_addr resumes at 11, no address skipped or duplicated.
REQ-034 Scan phase with pix_done returned 2 cycles after each new_pixel -> 36 new_pixel pulses, center_addr 0..35, a single done pulse after center 35, busy falls on the following cycle.
REQ-035 pix_done on the ISSUE cycle and while in IDLE, plus start during LOAD -> no state change and center_addr unaffected.
REQ-036 reset asserted in WAIT at center 17 -> all outputs 0 asynchronously, no done pulse; new start -> LOAD from address 0.
REQ-037 With EDA_SCAN_TIMEOUT_EN, TIMEOUT=64 and no pix_done at center 5 -> after 64 WAIT cycles timeout_err=1 and center_addr=6; the next start clears timeout_err.
